// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/decode pipeline control block:
// FSM state encodings, the default load-use bubble count and the width
// of the internal bubble-remaining counter.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_RSVD  = 2'b10,   // unused encoding, recovers to ST_RUN
        ST_HALT  = 2'b11
    } state_t;

    // Bubbles inserted per load-use hazard unless overridden (legal 1..15).
    localparam int unsigned LOAD_STALL_CYCLES_DEF = 1;

    // Width of the bubbles-remaining counter; holds up to 15.
    localparam int unsigned REM_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// synchronous clear wins over a same-cycle increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count register with clear priority and saturation at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage pipeline control: turns ID-stage hazard/redirect events and
// debug halt/resume into PC / IF-ID / ID-EX control, and counts load-use
// bubbles and redirects. Control outputs respond in the same cycle; the
// FSM state and the counters are registered.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_use,
    input  logic                 branch_taken,
    input  logic                 jump,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic                 cnt_clr,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;       // bubbles still to insert, STALL only
    logic             pend_q, pend_d;     // halt requested while stalling
    logic             arm_q, arm_d;       // halt_req is honoured only while armed
    logic             stall_inc, flush_inc;

    wire halt_ok  = halt_req & arm_q;
    wire redirect = branch_taken | jump;

    assign state = state_q;

    // Next-state and same-cycle pipeline control decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_d    = state_q;
        rem_d      = rem_q;
        pend_d     = pend_q;

        unique case (state_q)
            ST_RUN: begin
                if (halt_ok) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    state_d = ST_HALT;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = ST_STALL;
                        rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
            end
            ST_STALL: begin
                // Redirects and new hazards are ignored until the bubbles drain.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall_inc  = 1'b1;
                rem_d      = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d = (pend_q || halt_ok) ? ST_HALT : ST_RUN;
                    pend_d  = 1'b0;
                end else if (halt_ok) begin
                    pend_d = 1'b1;
                end
            end
            ST_HALT: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Re-arm once halt_req drops; disarm when resuming with it still high.
        if (!halt_req) begin
            arm_d = 1'b1;
        end else if ((state_q == ST_HALT) && resume) begin
            arm_d = 1'b0;
        end else begin
            arm_d = arm_q;
        end
    end

    // FSM state, stall bookkeeping and halt arming registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            arm_q   <= arm_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .clr     (cnt_clr),
        .count   (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .clr     (cnt_clr),
        .count   (flush_count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances share stimulus -- a 3-bubble, 16-bit
// counter instance and a 1-bubble, 4-bit counter instance (reaches
// saturation quickly). A behavioural model checks both every cycle,
// directed sequences pin key scenarios with literal values, then random
// traffic runs.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic reset_n, load_use, branch_taken, jump, halt_req, resume, cnt_clr;

    logic        pc_en_w [2];
    logic        ifid_en_w [2];
    logic        ifid_flush_w [2];
    logic        idex_flush_w [2];
    logic [1:0]  state_w [2];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
    logic [15:0] sc_w [2];
    logic [15:0] fc_w [2];

    assign sc_w[0] = sc0;
    assign fc_w[0] = fc0;
    assign sc_w[1] = {12'b0, sc1};
    assign fc_w[1] = {12'b0, fc1};

    always #5 clk = ~clk;

    fetch_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_use(load_use), .branch_taken(branch_taken),
        .jump(jump), .halt_req(halt_req), .resume(resume), .cnt_clr(cnt_clr),
        .pc_en(pc_en_w[0]), .ifid_en(ifid_en_w[0]), .ifid_flush(ifid_flush_w[0]),
        .idex_flush(idex_flush_w[0]), .state(state_w[0]),
        .stall_count(sc0), .flush_count(fc0)
    );

    fetch_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_use(load_use), .branch_taken(branch_taken),
        .jump(jump), .halt_req(halt_req), .resume(resume), .cnt_clr(cnt_clr),
        .pc_en(pc_en_w[1]), .ifid_en(ifid_en_w[1]), .ifid_flush(ifid_flush_w[1]),
        .idex_flush(idex_flush_w[1]), .state(state_w[1]),
        .stall_count(sc1), .flush_count(fc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lsc  [2] = '{3, 1};
    int cmax [2] = '{65535, 15};
    bit m_halted [2];
    bit m_pend   [2];
    bit m_armed  [2];
    int m_bub    [2];   // bubbles still owed after the current one; >0 means stalling
    int m_sc     [2];
    int m_fc     [2];

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_halted[i] = 1'b0;
            m_pend[i]   = 1'b0;
            m_armed[i]  = 1'b1;
            m_bub[i]    = 0;
            m_sc[i]     = 0;
            m_fc[i]     = 0;
        end
    endfunction

    initial m_reset();

    // Compare DUT against model on the falling edge, then advance the model.
    always @(negedge clk) begin
        if (!reset_n) m_reset();
        for (int i = 0; i < 2; i++) begin
            bit e_pc, e_ifid, e_iff, e_idf, inc_s, inc_f, hreq, was_halted;
            int e_st;
            e_pc = 1'b1; e_ifid = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
            inc_s = 1'b0; inc_f = 1'b0;
            hreq = halt_req && m_armed[i];
            e_st = m_halted[i] ? 3 : ((m_bub[i] > 0) ? 1 : 0);
            if (m_halted[i]) begin
                e_pc = 1'b0; e_ifid = 1'b0;
            end else if (m_bub[i] > 0) begin
                e_pc = 1'b0; e_ifid = 1'b0; e_idf = 1'b1; inc_s = 1'b1;
            end else if (hreq) begin
                e_pc = 1'b0; e_ifid = 1'b0;
            end else if (branch_taken || jump) begin
                e_iff = 1'b1; inc_f = 1'b1;
            end else if (load_use) begin
                e_pc = 1'b0; e_ifid = 1'b0; e_idf = 1'b1; inc_s = 1'b1;
            end

            check($sformatf("pc_en[%0d]", i),       32'(pc_en_w[i]),      32'(e_pc));
            check($sformatf("ifid_en[%0d]", i),     32'(ifid_en_w[i]),    32'(e_ifid));
            check($sformatf("ifid_flush[%0d]", i),  32'(ifid_flush_w[i]), 32'(e_iff));
            check($sformatf("idex_flush[%0d]", i),  32'(idex_flush_w[i]), 32'(e_idf));
            check($sformatf("state[%0d]", i),       32'(state_w[i]),      32'(e_st));
            check($sformatf("stall_count[%0d]", i), 32'(sc_w[i]),         32'(m_sc[i]));
            check($sformatf("flush_count[%0d]", i), 32'(fc_w[i]),         32'(m_fc[i]));

            if (reset_n) begin
                if (cnt_clr) begin
                    m_sc[i] = 0;
                    m_fc[i] = 0;
                end else begin
                    if (inc_s && m_sc[i] < cmax[i]) m_sc[i]++;
                    if (inc_f && m_fc[i] < cmax[i]) m_fc[i]++;
                end
                was_halted = m_halted[i];
                if (m_halted[i]) begin
                    if (resume) m_halted[i] = 1'b0;
                end else if (m_bub[i] > 0) begin
                    if (hreq) m_pend[i] = 1'b1;
                    m_bub[i]--;
                    if (m_bub[i] == 0 && m_pend[i]) begin
                        m_halted[i] = 1'b1;
                        m_pend[i]   = 1'b0;
                    end
                end else if (hreq) begin
                    m_halted[i] = 1'b1;
                end else if (!(branch_taken || jump) && load_use) begin
                    m_bub[i] = lsc[i] - 1;
                end
                if (!halt_req) m_armed[i] = 1'b1;
                else if (was_halted && resume) m_armed[i] = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_use = 0; branch_taken = 0; jump = 0; resume = 0; cnt_clr = 0;
    endtask

    initial begin
        int cnt;
        idle();
        halt_req = 0;
        reset_n  = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Reset release, idle for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            cyc(); #1;
            check("idle_pc_en", 32'(pc_en_w[0]), 32'd1);
            check("idle_state", 32'(state_w[0]), 32'd0);
        end
        check("idle_stall_count", 32'(sc0), 32'd0);
        check("idle_flush_count", 32'(fc0), 32'd0);

        // Single load-use pulse gives exactly three bubbles.
        cyc(); load_use = 1; #1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (pc_en_w[0] == 1'b0 && idex_flush_w[0] == 1'b1) cnt++;
            cyc(); load_use = 0; #1;
        end
        check("lu_bubbles", 32'(cnt), 32'd3);
        check("lu_stall_count", 32'(sc0), 32'd3);
        check("lu_back_to_run", 32'(state_w[0]), 32'd0);

        // Redirect beats load-use in the same cycle.
        cyc(); cnt_clr = 1;
        cyc(); cnt_clr = 0; branch_taken = 1; load_use = 1; #1;
        check("prio_ifid_flush", 32'(ifid_flush_w[0]), 32'd1);
        check("prio_pc_en", 32'(pc_en_w[0]), 32'd1);
        check("prio_idex_flush", 32'(idex_flush_w[0]), 32'd0);
        cyc(); idle(); #1;
        check("prio_flush_count", 32'(fc0), 32'd1);
        check("prio_stall_count", 32'(sc0), 32'd0);

        // Halt requested mid-stall: stall completes, then HALT until resume.
        cyc(); load_use = 1; #1;
        cnt = (pc_en_w[0] == 1'b0) ? 1 : 0;
        cyc(); load_use = 0; halt_req = 1; #1;
        if (pc_en_w[0] == 1'b0) cnt++;
        cyc(); #1;
        if (pc_en_w[0] == 1'b0) cnt++;
        cyc(); #1;
        check("hs_bubbles", 32'(cnt), 32'd3);
        check("hs_state_halt", 32'(state_w[0]), 32'd3);
        check("hs_stall_count", 32'(sc0), 32'd3);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            check("hs_halt_pc_en", 32'(pc_en_w[0]), 32'd0);
        end
        cyc(); resume = 1;
        cyc(); resume = 0; #1;
        check("hs_resume_state", 32'(state_w[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            check("hs_no_rehalt_state", 32'(state_w[0]), 32'd0);
            check("hs_no_rehalt_pc_en", 32'(pc_en_w[0]), 32'd1);
        end
        cyc(); halt_req = 0;
        cyc(); halt_req = 1; #1;
        check("hs_rearm_pc_en", 32'(pc_en_w[0]), 32'd0);
        cyc(); #1;
        check("hs_rearm_state", 32'(state_w[0]), 32'd3);
        cyc(); halt_req = 0; resume = 1;
        cyc(); resume = 0; #1;
        check("hs_final_state", 32'(state_w[0]), 32'd0);

        // Saturation on the 4-bit instance, then clear beats increment.
        cyc(); cnt_clr = 1;
        cyc(); cnt_clr = 0; jump = 1;
        repeat (14) cyc();
        jump = 0; #1;
        check("sat_pre", 32'(fc1), 32'hE);
        jump = 1;
        repeat (3) cyc();
        jump = 0; #1;
        check("sat_hold", 32'(fc1), 32'hF);
        jump = 1; cnt_clr = 1;
        cyc(); jump = 0; cnt_clr = 0; #1;
        check("sat_clr_small", 32'(fc1), 32'd0);
        check("sat_clr_big", 32'(fc0), 32'd0);

        // Reset while stalling with a halt pending.
        cyc(); load_use = 1;
        cyc(); load_use = 0; halt_req = 1;
        cyc(); #1;
        reset_n = 0; halt_req = 0; #1;
        check("rst_state", 32'(state_w[0]), 32'd0);
        check("rst_pc_en", 32'(pc_en_w[0]), 32'd1);
        repeat (2) cyc();
        reset_n = 1;
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            check("rst_no_halt", 32'(state_w[0]), 32'd0);
        end

        // Random traffic, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            cyc();
            load_use     = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump         = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 7) == 0);
            cnt_clr      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            reset_n      = ($urandom_range(0, 499) != 0);
        end
        cyc(); idle(); reset_n = 1;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
